csr_write_unit: RTL and testbench
=================================

CSR_WRITE_UNIT -- requirements
Module: csr_write_unit

Interface
REQ-001 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_in, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port wr_en_in, input, 1, CSR instruction write request this cycle.
REQ-004 SHALL have port csr_addr_in, input, 12, target CSR address.
REQ-005 SHALL have port csr_op_in, input, 2, operation: 00 none, 01 write, 10 set, 11 clear.
REQ-006 SHALL have port wr_data_in, input, 32, source operand (rs1 value or zero-extended uimm).
REQ-007 SHALL have port instret_inc_in, input, 1, one instruction retired this cycle.
REQ-008 SHALL have ports mstatus_out, mie_reg_out, mtvec_out, mscratch_out, mepc_out, mcause_out, mtval_out, mcountinhibit_out, output, 32 each, registered CSR values.
REQ-009 SHALL have ports mcycle_out, minstret_out, output, 64 each, registered counters.
REQ-010 SHALL have port illegal_wr_out, output, 1, registered one-cycle pulse flagging a rejected write.

Function
REQ-011 SHALL treat a cycle as a write when wr_en_in=1 and csr_op_in!=00, except op 10/11 with wr_data_in=0, which SHALL be no write and no error.
REQ-012 SHALL compute new value as: op01 wr_data_in; op10 old OR wr_data_in; op11 old AND NOT wr_data_in; old = current register value.
REQ-013 SHALL apply write masks: mstatus only bits 3 (MIE) and 7 (MPIE), MPP[12:11] reads 11; mie 0x0000_0888; mtvec bit 1 forced 0; mepc bits[1:0] forced 0; mcountinhibit 0x0000_0005; mscratch, mcause, mtval all 32 bits.
REQ-014 SHALL write MCYCLE (B00)/MINSTRET (B02) to counter bits[31:0] and MCYCLEH (B80)/MINSTRETH (B82) to bits[63:32], the other half unchanged.
REQ-015 SHALL reject writes to read-only addresses C00-C02, C80-C82, 301 (misa) and any unlisted address: no state change, illegal_wr_out=1 in the following cycle.
REQ-016 SHALL make written values visible on outputs the cycle after the write edge (latency 1).
REQ-017 SHALL increment mcycle by 1 every cycle unless mcountinhibit_out[0]=1.
REQ-018 SHALL increment minstret by 1 when instret_inc_in=1 unless mcountinhibit_out[2]=1.
REQ-019 SHALL propagate carry across the 32-bit boundary and wrap 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-020 SHALL suppress the whole 64-bit increment of a counter in any cycle that writes either of its halves; written value wins.
REQ-021 SHALL honour an mcountinhibit write starting the cycle after it; the increment in the write cycle uses the old inhibit value.
REQ-022 SHALL keep illegal_wr_out low in all other cycles; back-to-back illegal writes give consecutive high cycles.

Reset
REQ-023 SHALL on rst_in=1 set all CSR registers, mcycle, minstret to 0 (mstatus_out reads 0x0000_1800) and illegal_wr_out to 0.
REQ-024 SHALL give reset priority over any write or increment in the same cycle; first increment occurs on the first edge with rst_in=0.

Structure
REQ-025 SHALL take CSR address constants, op encodings and write masks from shared package csr_pkg, also used by the read mux.
REQ-026 SHALL implement each 64-bit counter as an instance of sub-module csr_counter64 (inputs: inc, inhibit, wr_lo, wr_hi, data).

Verification
REQ-027 Reset then 10 idle cycles -> mcycle_out=10, minstret_out=0, others 0, mstatus_out=0x0000_1800.
REQ-028 Write mscratch 0xF0F0_F0F0, set 0x0000_000F, clear 0xF000_0000 -> mscratch_out 0xF0F0_F0F0, 0xF0F0_F0FF, 0x00F0_F0FF.
REQ-029 Write MCYCLE=0xFFFF_FFFF, MCYCLEH=0 -> next cycles mcycle_out 0x0000_0001_0000_0000 then 0x0000_0001_0000_0001.
REQ-030 Write MINSTRETH=0xFFFF_FFFF, MINSTRET=0xFFFF_FFFF, instret_inc_in=1 next cycle -> minstret_out=0.
REQ-031 Write 0x1234 to C00 -> illegal_wr_out=1 for one cycle, mcycle continues; set C00 with data 0 -> illegal_wr_out stays 0.
REQ-032 Write mcountinhibit=0xFFFF_FFFF -> reads 0x5, mcycle frozen from next cycle; write mie=0xFFFF_FFFF -> 0x888; mepc=0x1003 -> 0x1000.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR block.
// Holds the CSR address map, the operation encoding and the per-register
// write masks. The write path and the read mux both use these, so the
// address decode and the masking come from one place.
// Ports: none (package).
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    // Writable machine CSRs. Any address not listed here is rejected.
    // This covers misa (0x301) and the read-only user counters C00-C02 and C80-C82.
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;

    // Write masks. A 1 marks a bit that a write can change.
    localparam logic [31:0] MSTATUS_WMASK       = 32'h0000_0088; // MIE, MPIE
    localparam logic [31:0] MSTATUS_FIXED       = 32'h0000_1800; // MPP hardwired to 11
    localparam logic [31:0] MIE_WMASK           = 32'h0000_0888;
    localparam logic [31:0] MTVEC_WMASK         = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_WMASK          = 32'hFFFF_FFFC;
    localparam logic [31:0] MCOUNTINHIBIT_WMASK = 32'h0000_0005;

    // Combines the current register value with the source operand.
    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] src);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = src;
            CSR_OP_SET:   res = old_val | src;
            CSR_OP_CLEAR: res = old_val & ~src;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_write_unit_counter64.sv
// 64-bit performance counter: csr_counter64.
// A write to either 32-bit half takes priority and suppresses the whole
// increment for that cycle. Otherwise the counter increments when the
// increment request is high and the counter is not inhibited.
// Ports:
//   clk_in, rst_in     clock and synchronous active-high reset
//   inc_in             increment request for this cycle
//   inhibit_in         blocks the increment when high
//   wr_lo_in, wr_hi_in load data_in into bits [31:0] / [63:32]
//   data_in            32-bit write data
//   count_out          registered 64-bit count
module csr_counter64 (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        inc_in,
    input  logic        inhibit_in,
    input  logic        wr_lo_in,
    input  logic        wr_hi_in,
    input  logic [31:0] data_in,
    output logic [63:0] count_out
);

    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (wr_lo_in || wr_hi_in) begin
            if (wr_lo_in) count_d[31:0]  = data_in;
            if (wr_hi_in) count_d[63:32] = data_in;
        end else if (inc_in && !inhibit_in) begin
            // Full-width add: carries across bit 32, and all-ones wraps to 0.
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_out = count_q;

endmodule

// File: rtl/csr_write_unit.sv
// Machine-mode CSR write unit.
// Decodes one CSR instruction per cycle and applies write, set or clear to
// the addressed register with its write mask. It also keeps mcycle and
// minstret running and flags writes to read-only or unknown addresses.
// Ports:
//   clk_in, rst_in        clock and synchronous active-high reset
//   wr_en_in              CSR instruction write request
//   csr_addr_in           target CSR address
//   csr_op_in             00 none, 01 write, 10 set, 11 clear
//   wr_data_in            source operand
//   instret_inc_in        one instruction retired this cycle
//   *_out (32-bit)        registered machine CSR values
//   mcycle_out, minstret_out  registered 64-bit counters
//   illegal_wr_out        one-cycle pulse after a rejected write
module csr_write_unit
    import csr_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_en_in,
    input  logic [11:0] csr_addr_in,
    input  logic [1:0]  csr_op_in,
    input  logic [31:0] wr_data_in,
    input  logic        instret_inc_in,
    output logic [31:0] mstatus_out,
    output logic [31:0] mie_reg_out,
    output logic [31:0] mtvec_out,
    output logic [31:0] mscratch_out,
    output logic [31:0] mepc_out,
    output logic [31:0] mcause_out,
    output logic [31:0] mtval_out,
    output logic [31:0] mcountinhibit_out,
    output logic [63:0] mcycle_out,
    output logic [63:0] minstret_out,
    output logic        illegal_wr_out
);

    csr_op_e     op;
    logic        wr_active;
    logic        addr_ok;
    logic [31:0] old_val, new_val;

    // mstatus_q holds only the writable bits. MPP is ORed in on read.
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mcountinhibit_q, mcountinhibit_d;
    logic        illegal_wr_q, illegal_wr_d;

    logic        mcycle_wr_lo, mcycle_wr_hi, minstret_wr_lo, minstret_wr_hi;
    logic [63:0] mcycle_val, minstret_val;

    assign op = csr_op_e'(csr_op_in);

    // Set or clear with a zero operand reads the CSR but never writes it.
    // That case cannot raise an illegal-write error either.
    assign wr_active = wr_en_in && (op != CSR_OP_NONE) &&
                       !(((op == CSR_OP_SET) || (op == CSR_OP_CLEAR)) &&
                         (wr_data_in == 32'd0));

    // Read mux: current architectural value of the addressed CSR
    always_comb begin
        addr_ok = 1'b1;
        old_val = 32'd0;
        case (csr_addr_in)
            CSR_MSTATUS:       old_val = mstatus_q | MSTATUS_FIXED;
            CSR_MIE:           old_val = mie_q;
            CSR_MTVEC:         old_val = mtvec_q;
            CSR_MCOUNTINHIBIT: old_val = mcountinhibit_q;
            CSR_MSCRATCH:      old_val = mscratch_q;
            CSR_MEPC:          old_val = mepc_q;
            CSR_MCAUSE:        old_val = mcause_q;
            CSR_MTVAL:         old_val = mtval_q;
            CSR_MCYCLE:        old_val = mcycle_val[31:0];
            CSR_MCYCLEH:       old_val = mcycle_val[63:32];
            CSR_MINSTRET:      old_val = minstret_val[31:0];
            CSR_MINSTRETH:     old_val = minstret_val[63:32];
            default:           addr_ok = 1'b0;
        endcase
    end

    assign new_val = csr_apply_op(op, old_val, wr_data_in);

    always_comb begin
        mstatus_d       = mstatus_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        mcountinhibit_d = mcountinhibit_q;
        mcycle_wr_lo    = 1'b0;
        mcycle_wr_hi    = 1'b0;
        minstret_wr_lo  = 1'b0;
        minstret_wr_hi  = 1'b0;
        illegal_wr_d    = wr_active && !addr_ok;
        if (wr_active && addr_ok) begin
            case (csr_addr_in)
                CSR_MSTATUS:       mstatus_d       = new_val & MSTATUS_WMASK;
                CSR_MIE:           mie_d           = new_val & MIE_WMASK;
                CSR_MTVEC:         mtvec_d         = new_val & MTVEC_WMASK;
                CSR_MCOUNTINHIBIT: mcountinhibit_d = new_val & MCOUNTINHIBIT_WMASK;
                CSR_MSCRATCH:      mscratch_d      = new_val;
                CSR_MEPC:          mepc_d          = new_val & MEPC_WMASK;
                CSR_MCAUSE:        mcause_d        = new_val;
                CSR_MTVAL:         mtval_d         = new_val;
                CSR_MCYCLE:        mcycle_wr_lo    = 1'b1;
                CSR_MCYCLEH:       mcycle_wr_hi    = 1'b1;
                CSR_MINSTRET:      minstret_wr_lo  = 1'b1;
                CSR_MINSTRETH:     minstret_wr_hi  = 1'b1;
                default:           ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mstatus_q       <= '0;
            mie_q           <= '0;
            mtvec_q         <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mcountinhibit_q <= '0;
            illegal_wr_q    <= 1'b0;
        end else begin
            mstatus_q       <= mstatus_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            mcountinhibit_q <= mcountinhibit_d;
            illegal_wr_q    <= illegal_wr_d;
        end
    end

    // The counters see the registered inhibit bits. A new mcountinhibit
    // value therefore takes effect one cycle after its write.
    csr_counter64 u_mcycle (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .inc_in     (1'b1),
        .inhibit_in (mcountinhibit_q[0]),
        .wr_lo_in   (mcycle_wr_lo),
        .wr_hi_in   (mcycle_wr_hi),
        .data_in    (new_val),
        .count_out  (mcycle_val)
    );

    csr_counter64 u_minstret (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .inc_in     (instret_inc_in),
        .inhibit_in (mcountinhibit_q[2]),
        .wr_lo_in   (minstret_wr_lo),
        .wr_hi_in   (minstret_wr_hi),
        .data_in    (new_val),
        .count_out  (minstret_val)
    );

    assign mstatus_out       = mstatus_q | MSTATUS_FIXED;
    assign mie_reg_out       = mie_q;
    assign mtvec_out         = mtvec_q;
    assign mscratch_out      = mscratch_q;
    assign mepc_out          = mepc_q;
    assign mcause_out        = mcause_q;
    assign mtval_out         = mtval_q;
    assign mcountinhibit_out = mcountinhibit_q;
    assign mcycle_out        = mcycle_val;
    assign minstret_out      = minstret_val;
    assign illegal_wr_out    = illegal_wr_q;

endmodule

// File: tb/tb_csr_write_unit.sv
module tb_csr_write_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        wr_en_in = 1'b0;
    logic [11:0] csr_addr_in = 12'h000;
    logic [1:0]  csr_op_in = 2'b00;
    logic [31:0] wr_data_in = 32'd0;
    logic        instret_inc_in = 1'b0;
    logic [31:0] mstatus_out, mie_reg_out, mtvec_out, mscratch_out, mepc_out;
    logic [31:0] mcause_out, mtval_out, mcountinhibit_out;
    logic [63:0] mcycle_out, minstret_out;
    logic        illegal_wr_out;

    int tests = 0;
    int failed = 0;

    always #5 clk_in = ~clk_in;

    csr_write_unit dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .wr_en_in          (wr_en_in),
        .csr_addr_in       (csr_addr_in),
        .csr_op_in         (csr_op_in),
        .wr_data_in        (wr_data_in),
        .instret_inc_in    (instret_inc_in),
        .mstatus_out       (mstatus_out),
        .mie_reg_out       (mie_reg_out),
        .mtvec_out         (mtvec_out),
        .mscratch_out      (mscratch_out),
        .mepc_out          (mepc_out),
        .mcause_out        (mcause_out),
        .mtval_out         (mtval_out),
        .mcountinhibit_out (mcountinhibit_out),
        .mcycle_out        (mcycle_out),
        .minstret_out      (minstret_out),
        .illegal_wr_out    (illegal_wr_out)
    );

    typedef enum int {
        S_MSTATUS, S_MIE, S_MTVEC, S_MSCRATCH, S_MEPC, S_MCAUSE,
        S_MTVAL, S_MCNTINH, S_MCYCLE, S_MINSTRET
    } sel_e;

    typedef struct {
        logic        wr;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] data;
        sel_e        sel;
        logic [63:0] exp;
        logic        exp_ill;
    } vec_t;

    vec_t vq[$];

    localparam logic [1:0] OP_N = 2'b00, OP_W = 2'b01, OP_S = 2'b10, OP_C = 2'b11;

    function automatic logic [63:0] get_out(input sel_e s);
        case (s)
            S_MSTATUS:  return {32'd0, mstatus_out};
            S_MIE:      return {32'd0, mie_reg_out};
            S_MTVEC:    return {32'd0, mtvec_out};
            S_MSCRATCH: return {32'd0, mscratch_out};
            S_MEPC:     return {32'd0, mepc_out};
            S_MCAUSE:   return {32'd0, mcause_out};
            S_MTVAL:    return {32'd0, mtval_out};
            S_MCNTINH:  return {32'd0, mcountinhibit_out};
            S_MCYCLE:   return mcycle_out;
            default:    return minstret_out;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] o, input logic [11:0] a,
                         input logic [31:0] d, input logic inc);
        wr_en_in       = w;
        csr_op_in      = o;
        csr_addr_in    = a;
        wr_data_in     = d;
        instret_inc_in = inc;
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] o, input logic [11:0] a,
                                input logic [31:0] d, input sel_e s, input logic [63:0] e,
                                input logic ill);
        vec_t v;
        v.wr = w; v.op = o; v.addr = a; v.data = d;
        v.sel = s; v.exp = e; v.exp_ill = ill;
        return v;
    endfunction

    initial begin
        // Vector table: one cycle each, checked after the edge
        vq.push_back(mk(1, OP_W, 12'h340, 32'hF0F0_F0F0, S_MSCRATCH, 64'hF0F0_F0F0, 0));
        vq.push_back(mk(1, OP_S, 12'h340, 32'h0000_000F, S_MSCRATCH, 64'hF0F0_F0FF, 0));
        vq.push_back(mk(1, OP_C, 12'h340, 32'hF000_0000, S_MSCRATCH, 64'h00F0_F0FF, 0));
        vq.push_back(mk(1, OP_C, 12'h340, 32'h0000_0000, S_MSCRATCH, 64'h00F0_F0FF, 0));
        vq.push_back(mk(1, OP_W, 12'h304, 32'hFFFF_FFFF, S_MIE,      64'h0000_0888, 0));
        vq.push_back(mk(1, OP_C, 12'h304, 32'h0000_0008, S_MIE,      64'h0000_0880, 0));
        vq.push_back(mk(1, OP_W, 12'h341, 32'h0000_1003, S_MEPC,     64'h0000_1000, 0));
        vq.push_back(mk(1, OP_W, 12'h305, 32'hFFFF_FFFF, S_MTVEC,    64'hFFFF_FFFD, 0));
        vq.push_back(mk(1, OP_W, 12'h300, 32'hFFFF_FFFF, S_MSTATUS,  64'h0000_1888, 0));
        vq.push_back(mk(1, OP_C, 12'h300, 32'h0000_0008, S_MSTATUS,  64'h0000_1880, 0));
        vq.push_back(mk(1, OP_S, 12'h300, 32'h0000_0000, S_MSTATUS,  64'h0000_1880, 0));
        vq.push_back(mk(1, OP_W, 12'h342, 32'h8000_000B, S_MCAUSE,   64'h8000_000B, 0));
        vq.push_back(mk(1, OP_W, 12'h343, 32'hDEAD_BEEF, S_MTVAL,    64'hDEAD_BEEF, 0));
        vq.push_back(mk(1, OP_W, 12'hC00, 32'h0000_1234, S_MSCRATCH, 64'h00F0_F0FF, 1));
        vq.push_back(mk(1, OP_W, 12'h301, 32'hFFFF_FFFF, S_MSTATUS,  64'h0000_1880, 1));
        vq.push_back(mk(1, OP_S, 12'h7FF, 32'h0000_0001, S_MSCRATCH, 64'h00F0_F0FF, 1));
        vq.push_back(mk(1, OP_W, 12'hC82, 32'h0000_0001, S_MINSTRET, 64'h0,         1));
        vq.push_back(mk(1, OP_S, 12'hC00, 32'h0000_0000, S_MSCRATCH, 64'h00F0_F0FF, 0));
        vq.push_back(mk(1, OP_N, 12'hC00, 32'h0000_1234, S_MSCRATCH, 64'h00F0_F0FF, 0));
        vq.push_back(mk(0, OP_W, 12'hC00, 32'h0000_1234, S_MSCRATCH, 64'h00F0_F0FF, 0));
        vq.push_back(mk(0, OP_W, 12'h340, 32'h1111_1111, S_MSCRATCH, 64'h00F0_F0FF, 0));

        // Reset with a write and a retire pending: reset wins
        drive(1, OP_W, 12'h340, 32'h5555_5555, 1);
        rst_in = 1'b1;
        cycle();
        cycle();
        check("rst_mstatus", {32'd0, mstatus_out}, 64'h0000_1800);
        check("rst_mscratch", {32'd0, mscratch_out}, 64'h0);
        check("rst_mie", {32'd0, mie_reg_out}, 64'h0);
        check("rst_mcntinh", {32'd0, mcountinhibit_out}, 64'h0);
        check("rst_mcycle", mcycle_out, 64'h0);
        check("rst_minstret", minstret_out, 64'h0);
        check("rst_illegal", {63'd0, illegal_wr_out}, 64'h0);

        rst_in = 1'b0;
        drive(0, OP_N, 12'h000, 32'h0, 0);
        for (int i = 0; i < 10; i++) cycle();
        check("idle_mcycle", mcycle_out, 64'd10);
        check("idle_minstret", minstret_out, 64'd0);
        check("idle_mtvec", {32'd0, mtvec_out}, 64'h0);

        foreach (vq[i]) begin
            drive(vq[i].wr, vq[i].op, vq[i].addr, vq[i].data, 0);
            cycle();
            tests++;
            if (get_out(vq[i].sel) !== vq[i].exp) begin
                failed++;
                $display("FAIL vec%0d value: got 0x%016h, expected 0x%016h",
                         i, get_out(vq[i].sel), vq[i].exp);
            end
            tests++;
            if (illegal_wr_out !== vq[i].exp_ill) begin
                failed++;
                $display("FAIL vec%0d illegal_wr: got %0b, expected %0b",
                         i, illegal_wr_out, vq[i].exp_ill);
            end
        end
        drive(0, OP_N, 12'h000, 32'h0, 0);
        check("table_mcycle", mcycle_out, 64'd10 + 64'(vq.size()));

        // mcycle: low half to all ones, then high half to zero, then carry
        drive(1, OP_W, 12'hB00, 32'hFFFF_FFFF, 0);
        cycle();
        check("mcycle_lo_wr", {32'd0, mcycle_out[31:0]}, 64'hFFFF_FFFF);
        drive(1, OP_W, 12'hB80, 32'h0, 0);
        cycle();
        check("mcycle_hi_wr", mcycle_out, 64'h0000_0000_FFFF_FFFF);
        drive(0, OP_N, 12'h000, 32'h0, 0);
        cycle();
        check("mcycle_carry", mcycle_out, 64'h0000_0001_0000_0000);
        cycle();
        check("mcycle_carry2", mcycle_out, 64'h0000_0001_0000_0001);

        // minstret: write both halves to all ones with retire held high, then wrap
        drive(1, OP_W, 12'hB82, 32'hFFFF_FFFF, 1);
        cycle();
        check("minstret_hi_wr", minstret_out, 64'hFFFF_FFFF_0000_0000);
        drive(1, OP_W, 12'hB02, 32'hFFFF_FFFF, 1);
        cycle();
        check("minstret_lo_wr", minstret_out, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(0, OP_N, 12'h000, 32'h0, 1);
        cycle();
        check("minstret_wrap", minstret_out, 64'h0);
        cycle();
        check("minstret_inc", minstret_out, 64'h1);
        check("mcycle_before_inh", mcycle_out, 64'h0000_0001_0000_0005);

        // mcountinhibit: the write cycle still increments, and later cycles freeze
        drive(1, OP_W, 12'h320, 32'hFFFF_FFFF, 1);
        cycle();
        check("inh_value", {32'd0, mcountinhibit_out}, 64'h5);
        check("inh_wr_mcycle", mcycle_out, 64'h0000_0001_0000_0006);
        check("inh_wr_minstret", minstret_out, 64'h2);
        drive(0, OP_N, 12'h000, 32'h0, 1);
        cycle();
        cycle();
        check("inh_frozen_mcycle", mcycle_out, 64'h0000_0001_0000_0006);
        check("inh_frozen_minstret", minstret_out, 64'h2);
        drive(1, OP_W, 12'h320, 32'h0, 1);
        cycle();
        check("uninh_wr_mcycle", mcycle_out, 64'h0000_0001_0000_0006);
        drive(0, OP_N, 12'h000, 32'h0, 1);
        cycle();
        check("uninh_mcycle", mcycle_out, 64'h0000_0001_0000_0007);
        check("uninh_minstret", minstret_out, 64'h3);

        // Set on a counter half uses the current low word
        drive(1, OP_S, 12'hB00, 32'h0000_0100, 0);
        cycle();
        check("mcycle_set", mcycle_out, 64'h0000_0001_0000_0107);

        // Mid-run reset beats a simultaneous counter write
        drive(1, OP_W, 12'hB80, 32'h1234_5678, 1);
        rst_in = 1'b1;
        cycle();
        check("rst2_mcycle", mcycle_out, 64'h0);
        check("rst2_mscratch", {32'd0, mscratch_out}, 64'h0);
        rst_in = 1'b0;
        drive(0, OP_N, 12'h000, 32'h0, 0);
        cycle();
        check("rst2_first_inc", mcycle_out, 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
